// File: rtl/facto_sched_pkg.sv
// facto_sched_pkg: FSM encoding, FactoCore register map and watchdog width
// shared by the FactoCore scheduler and its arbiter.
package facto_sched_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_INIT0,
        S_IDLE,
        S_WR_OP,
        S_WR_IE,
        S_WR_GO,
        S_WAIT_INT,
        S_RD_H,
        S_RD_L,
        S_CLR1,
        S_CLR0,
        S_DONE
    } state_t;

    localparam logic [15:0] OFF_OPSTART  = 16'h0000;
    localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFF_INTREN   = 16'h0018;
    localparam logic [15:0] OFF_OPERAND  = 16'h0020;
    localparam logic [15:0] OFF_RESULT_H = 16'h0028;
    localparam logic [15:0] OFF_RESULT_L = 16'h0030;

    localparam int TMO_W = 32;

    function automatic logic [15:0] reg_addr(
        input logic [15:0] base,
        input logic [15:0] off
    );
        return base + off;
    endfunction

endpackage

// File: rtl/facto_scheduler_rr_arbiter.sv
// rr_arbiter: lowest requesting index at or after the pointer wins;
// returns a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int IW1 = IW + 1;

    logic [IW:0] w_sum;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // pointer + k wraps at most once since both are below NUM_REQ
            w_sum = {1'b0, i_ptr} + IW1'(k);
            if (w_sum >= IW1'(NUM_REQ)) begin
                w_sum = w_sum - IW1'(NUM_REQ);
            end
            if (!o_any && i_req[w_sum[IW-1:0]]) begin
                o_any                = 1'b1;
                o_gnt[w_sum[IW-1:0]] = 1'b1;
                o_idx                = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/facto_scheduler.sv
// facto_scheduler: round-robin bus master time-sharing one FactoCore engine.
// Optional WAIT_INT watchdog enabled by defining FACTO_SCHED_TIMEOUT_EN.
import facto_sched_pkg::*;

module facto_scheduler #(
    parameter int          NUM_REQ        = 2,
    parameter logic [15:0] BASE_ADDR      = 16'h7000,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [64*NUM_REQ-1:0]      req_operand,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [127:0]               resp_result,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       m_sel,
    output logic                       m_wr,
    output logic [15:0]                m_addr,
    output logic [63:0]                m_dout,
    input  logic [63:0]                m_din,
    input  logic                       interrupt
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("facto_scheduler: NUM_REQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("facto_scheduler: TIMEOUT_CYCLES must be positive");
    end

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_id;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_ptr_nx;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any;
    logic [63:0]        r_op;
    logic [63:0]        w_op;
    logic [127:0]       r_res;
    logic               r_int;
    logic               r_err;
    logic               w_tmo_hit;
    logic               w_run;
    logic               w_sel;
    logic               w_wr;
    logic [15:0]        w_addr;
    logic [63:0]        w_dout;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_op = req_operand[64*i +: 64];
            end
        end
    end

    assign w_ptr_nx = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_id    <= '0;
            r_op    <= '0;
            r_res   <= '0;
            r_ack   <= '0;
            r_int   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= '0;
            r_int   <= interrupt;
            if (r_state == S_IDLE && w_any) begin
                r_ack <= w_gnt;
                r_id  <= w_idx;
                r_op  <= w_op;
                r_ptr <= w_ptr_nx;
                r_err <= 1'b0;
            end
            if (w_tmo_hit) begin
                r_err <= 1'b1;
                r_res <= '0;
            end
            if (r_state == S_RD_L) begin
                r_res[127:64] <= m_din;
            end
            // an aborted job keeps its zeroed result
            if (r_state == S_CLR1) begin
                r_res[63:0] <= r_err ? 64'd0 : m_din;
            end
        end
    end

`ifdef FACTO_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= '0;
        end else if (r_state == S_WAIT_INT) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo_hit = (r_state == S_WAIT_INT) && !r_int &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign resp_err  = r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_sel  = 1'b0;
        w_wr   = 1'b0;
        w_addr = '0;
        w_dout = '0;
        unique case (r_state)
            S_INIT: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_OPCLEAR);
                w_dout = 64'd1;
                w_next = S_INIT0;
            end
            S_INIT0: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_OPCLEAR);
                w_next = S_IDLE;
            end
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_WR_OP;
                end
            end
            S_WR_OP: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_OPERAND);
                w_dout = r_op;
                w_next = S_WR_IE;
            end
            S_WR_IE: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_INTREN);
                w_dout = 64'd1;
                w_next = S_WR_GO;
            end
            S_WR_GO: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_OPSTART);
                w_dout = 64'd1;
                w_next = S_WAIT_INT;
            end
            S_WAIT_INT: begin
                if (r_int) begin
                    w_next = S_RD_H;
                end else if (w_tmo_hit) begin
                    w_next = S_CLR1;
                end
            end
            S_RD_H: begin
                w_sel  = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_RESULT_H);
                w_next = S_RD_L;
            end
            S_RD_L: begin
                w_sel  = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_RESULT_L);
                w_next = S_CLR1;
            end
            S_CLR1: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_OPCLEAR);
                w_dout = 64'd1;
                w_next = S_CLR0;
            end
            S_CLR0: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = reg_addr(BASE_ADDR, OFF_OPCLEAR);
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    // while reset is held every output stays low, INIT included
    assign w_run       = ~reset;
    assign m_sel       = w_run & w_sel;
    assign m_wr        = w_run & w_wr;
    assign m_addr      = w_run ? w_addr : 16'd0;
    assign m_dout      = w_run ? w_dout : 64'd0;
    assign busy        = w_run & (r_state != S_IDLE);
    assign req_ack     = r_ack;
    assign resp_valid  = w_run & (r_state == S_DONE);
    assign resp_id     = r_id;
    assign resp_result = r_res;

endmodule
